// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit accumulator CPU: bus sources, ALU modes, opcodes
// and the packed control-strobe bundle produced by the decoder.
package cpu_pkg;

  localparam logic [2:0] BusX   = 3'd0;
  localparam logic [2:0] BusAr  = 3'd1;
  localparam logic [2:0] BusPc  = 3'd2;
  localparam logic [2:0] BusDr  = 3'd3;
  localparam logic [2:0] BusAc  = 3'd4;
  localparam logic [2:0] BusIr  = 3'd5;
  localparam logic [2:0] BusTr  = 3'd6;
  localparam logic [2:0] BusMem = 3'd7;

  localparam logic [2:0] AluPass = 3'd0;
  localparam logic [2:0] AluAdd  = 3'd1;
  localparam logic [2:0] AluAnd  = 3'd2;
  localparam logic [2:0] AluOr   = 3'd3;
  localparam logic [2:0] AluXor  = 3'd4;
  localparam logic [2:0] AluNot  = 3'd5;
  localparam logic [2:0] AluShl  = 3'd6;
  localparam logic [2:0] AluShr  = 3'd7;

  localparam logic [3:0] OpLda = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpOr  = 4'h3;
  localparam logic [3:0] OpXor = 4'h4;
  localparam logic [3:0] OpSta = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpNot = 4'h7;
  localparam logic [3:0] OpShl = 4'h8;
  localparam logic [3:0] OpShr = 4'h9;
  localparam logic [3:0] OpCla = 4'hA;
  localparam logic [3:0] OpInc = 4'hB;
  localparam logic [3:0] OpIsz = 4'hC;
  localparam logic [3:0] OpLdx = 4'hD;

  typedef struct packed {
    logic       load_ar;
    logic       load_pc;
    logic       load_dr;
    logic       load_ac;
    logic       load_ir;
    logic       load_tr;
    logic       clear_ar;
    logic       clear_pc;
    logic       clear_dr;
    logic       clear_ac;
    logic       clear_tr;
    logic       inc_ar;
    logic       inc_pc;
    logic       inc_dr;
    logic       inc_ac;
    logic       inc_tr;
    logic       seq_reset;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] bus_sel;
    logic [2:0] alu_mode;
    logic       alu_enable;
  } ctrl_t;

  // Index of the lowest set bit; callers qualify with |t for the all-zero case.
  function automatic logic [2:0] lowest_step(input logic [7:0] t);
    logic [2:0] step;
    step = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (t[i]) step = 3'(i);
    end
    return step;
  endfunction

  function automatic logic [2:0] op_mode(input logic [3:0] op);
    logic [2:0] mode;
    case (op)
      OpAdd:   mode = AluAdd;
      OpAnd:   mode = AluAnd;
      OpOr:    mode = AluOr;
      OpXor:   mode = AluXor;
      OpNot:   mode = AluNot;
      OpShl:   mode = AluShl;
      OpShr:   mode = AluShr;
      default: mode = AluPass;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU; next_e_o carries the new link flag for ADD/SHL/SHR and
// echoes e_i for every other mode.
module alu8
  import cpu_pkg::*;
(
  input  logic [2:0] mode_i,
  input  logic [7:0] ac_i,
  input  logic [7:0] dr_i,
  input  logic       e_i,
  output logic [7:0] result_o,
  output logic       next_e_o
);

  always_comb begin
    result_o = dr_i;
    next_e_o = e_i;
    unique case (mode_i)
      AluPass: result_o = dr_i;
      AluAdd:  {next_e_o, result_o} = {1'b0, ac_i} + {1'b0, dr_i};
      AluAnd:  result_o = ac_i & dr_i;
      AluOr:   result_o = ac_i | dr_i;
      AluXor:  result_o = ac_i ^ dr_i;
      AluNot:  result_o = ~ac_i;
      AluShl: begin
        result_o = {ac_i[6:0], 1'b0};
        next_e_o = ac_i[7];
      end
      AluShr: begin
        result_o = {1'b0, ac_i[7:1]};
        next_e_o = ac_i[0];
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_datapath.sv
// Control unit, system bus multiplexer and ALU of the 8-bit accumulator CPU, with the
// registered link flag E.
module cpu_control_datapath
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] T,
  input  logic [7:0] IR,
  input  logic [7:0] DR,
  input  logic [7:0] AC,
  input  logic [7:0] TR,
  input  logic [7:0] X_DATA,
  input  logic [7:0] MEM_DATA,
  input  logic [3:0] AR,
  input  logic [3:0] PC,
  output logic       load_AR,
  output logic       load_PC,
  output logic       load_DR,
  output logic       load_AC,
  output logic       load_IR,
  output logic       load_TR,
  output logic       clear_AR,
  output logic       clear_PC,
  output logic       clear_DR,
  output logic       clear_AC,
  output logic       clear_TR,
  output logic       inc_AR,
  output logic       inc_PC,
  output logic       inc_DR,
  output logic       inc_AC,
  output logic       inc_TR,
  output logic       seq_counter_RESET,
  output logic       memory_read,
  output logic       memory_write,
  output logic [2:0] bus_sel,
  output logic [7:0] bus_out,
  output logic [2:0] alu_mode,
  output logic       alu_enable,
  output logic [7:0] alu_result,
  output logic       E
);

  ctrl_t      ctrl;
  logic [2:0] step;
  logic [3:0] opcode;
  logic [7:0] alu_out;
  logic       alu_next_e;
  logic       e_q;

  assign step   = lowest_step(T);
  assign opcode = IR[7:4];

  // Every step resets the sequence counter unless it explicitly continues.
  always_comb begin
    ctrl           = '0;
    ctrl.seq_reset = 1'b1;
    if (reset) begin
      ctrl.clear_ar = 1'b1;
      ctrl.clear_pc = 1'b1;
      ctrl.clear_dr = 1'b1;
      ctrl.clear_ac = 1'b1;
      ctrl.clear_tr = 1'b1;
    end else if (|T) begin
      unique case (step)
        3'd0: begin
          ctrl.bus_sel   = BusPc;
          ctrl.load_ar   = 1'b1;
          ctrl.seq_reset = 1'b0;
        end
        3'd1: begin
          ctrl.mem_read  = 1'b1;
          ctrl.bus_sel   = BusMem;
          ctrl.load_ir   = 1'b1;
          ctrl.inc_pc    = 1'b1;
          ctrl.seq_reset = 1'b0;
        end
        3'd2: begin
          ctrl.bus_sel   = BusIr;
          ctrl.load_ar   = 1'b1;
          ctrl.seq_reset = 1'b0;
        end
        3'd3: begin
          case (opcode)
            OpLda, OpAdd, OpAnd, OpOr, OpXor, OpIsz: begin
              ctrl.mem_read  = 1'b1;
              ctrl.bus_sel   = BusMem;
              ctrl.load_dr   = 1'b1;
              ctrl.seq_reset = 1'b0;
            end
            OpSta: begin
              ctrl.bus_sel   = BusAc;
              ctrl.mem_write = 1'b1;
            end
            OpJmp: begin
              ctrl.bus_sel = BusAr;
              ctrl.load_pc = 1'b1;
            end
            OpNot, OpShl, OpShr: begin
              ctrl.alu_enable = 1'b1;
              ctrl.alu_mode   = op_mode(opcode);
              ctrl.load_ac    = 1'b1;
            end
            OpCla: ctrl.clear_ac = 1'b1;
            OpInc: ctrl.inc_ac = 1'b1;
            OpLdx: begin
              ctrl.bus_sel   = BusX;
              ctrl.load_dr   = 1'b1;
              ctrl.seq_reset = 1'b0;
            end
            default: ;
          endcase
        end
        3'd4: begin
          case (opcode)
            OpLda, OpLdx, OpAdd, OpAnd, OpOr, OpXor: begin
              ctrl.alu_enable = 1'b1;
              ctrl.alu_mode   = op_mode(opcode);
              ctrl.load_ac    = 1'b1;
            end
            OpIsz: begin
              ctrl.inc_dr    = 1'b1;
              ctrl.seq_reset = 1'b0;
            end
            default: ;
          endcase
        end
        3'd5: begin
          if (opcode == OpIsz) begin
            ctrl.bus_sel   = BusDr;
            ctrl.mem_write = 1'b1;
            ctrl.inc_pc    = (DR == 8'h00);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_out = X_DATA;
    unique case (ctrl.bus_sel)
      BusX:   bus_out = X_DATA;
      BusAr:  bus_out = {4'b0000, AR};
      BusPc:  bus_out = {4'b0000, PC};
      BusDr:  bus_out = DR;
      BusAc:  bus_out = AC;
      BusIr:  bus_out = IR;
      BusTr:  bus_out = TR;
      BusMem: bus_out = MEM_DATA;
    endcase
  end

  alu8 u_alu (
    .mode_i   (ctrl.alu_mode),
    .ac_i     (AC),
    .dr_i     (DR),
    .e_i      (e_q),
    .result_o (alu_out),
    .next_e_o (alu_next_e)
  );

  // The ALU echoes e_q for modes that do not own the flag, so only the load gate matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= 1'b0;
    end else if (ctrl.load_ac && ctrl.alu_enable) begin
      e_q <= alu_next_e;
    end
  end

  assign load_AR           = ctrl.load_ar;
  assign load_PC           = ctrl.load_pc;
  assign load_DR           = ctrl.load_dr;
  assign load_AC           = ctrl.load_ac;
  assign load_IR           = ctrl.load_ir;
  assign load_TR           = ctrl.load_tr;
  assign clear_AR          = ctrl.clear_ar;
  assign clear_PC          = ctrl.clear_pc;
  assign clear_DR          = ctrl.clear_dr;
  assign clear_AC          = ctrl.clear_ac;
  assign clear_TR          = ctrl.clear_tr;
  assign inc_AR            = ctrl.inc_ar;
  assign inc_PC            = ctrl.inc_pc;
  assign inc_DR            = ctrl.inc_dr;
  assign inc_AC            = ctrl.inc_ac;
  assign inc_TR            = ctrl.inc_tr;
  assign seq_counter_RESET = ctrl.seq_reset;
  assign memory_read       = ctrl.mem_read;
  assign memory_write      = ctrl.mem_write;
  assign bus_sel           = ctrl.bus_sel;
  assign alu_mode          = ctrl.alu_mode;
  assign alu_enable        = ctrl.alu_enable;
  assign alu_result        = ctrl.alu_enable ? alu_out : AC;
  assign E                 = e_q;

endmodule

// File: tb/tb_cpu_control_datapath.sv
// Directed bench for cpu_control_datapath: expectations are queued as each step is
// driven and popped against the DUT outputs mid-cycle and just after the clock edge.
module tb_cpu_control_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] T, IR, DR, AC, TR, X_DATA, MEM_DATA;
  logic [3:0] AR, PC;
  logic       load_AR, load_PC, load_DR, load_AC, load_IR, load_TR;
  logic       clear_AR, clear_PC, clear_DR, clear_AC, clear_TR;
  logic       inc_AR, inc_PC, inc_DR, inc_AC, inc_TR;
  logic       seq_counter_RESET, memory_read, memory_write, alu_enable, E;
  logic [2:0] bus_sel, alu_mode;
  logic [7:0] bus_out, alu_result;

  always #5 clk = ~clk;

  cpu_control_datapath dut (
    .clk(clk), .reset(reset), .T(T), .IR(IR), .DR(DR), .AC(AC), .TR(TR),
    .X_DATA(X_DATA), .MEM_DATA(MEM_DATA), .AR(AR), .PC(PC),
    .load_AR(load_AR), .load_PC(load_PC), .load_DR(load_DR), .load_AC(load_AC),
    .load_IR(load_IR), .load_TR(load_TR),
    .clear_AR(clear_AR), .clear_PC(clear_PC), .clear_DR(clear_DR), .clear_AC(clear_AC),
    .clear_TR(clear_TR),
    .inc_AR(inc_AR), .inc_PC(inc_PC), .inc_DR(inc_DR), .inc_AC(inc_AC), .inc_TR(inc_TR),
    .seq_counter_RESET(seq_counter_RESET), .memory_read(memory_read),
    .memory_write(memory_write), .bus_sel(bus_sel), .bus_out(bus_out),
    .alu_mode(alu_mode), .alu_enable(alu_enable), .alu_result(alu_result), .E(E)
  );

  // Bit positions inside the packed strobe word returned by obs(FStr).
  localparam int SLAR = 19, SLPC = 18, SLDR = 17, SLAC = 16, SLIR = 15;
  localparam int SCAR = 13, SCPC = 12, SCDR = 11, SCAC = 10, SCTR = 9;
  localparam int SIPC = 7, SIDR = 6, SIAC = 5, SSR = 3, SMR = 2, SMW = 1, SAEN = 0;

  typedef enum int {FStr, FSel, FBus, FMode, FRes, FE} field_e;
  typedef struct {
    string      tag;
    field_e     f;
    logic [19:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [19:0] clr_all;

  function automatic logic [19:0] b(input int p);
    return 20'd1 << p;
  endfunction

  function automatic logic [19:0] obs(input field_e f);
    case (f)
      FStr:  return {load_AR, load_PC, load_DR, load_AC, load_IR, load_TR,
                     clear_AR, clear_PC, clear_DR, clear_AC, clear_TR,
                     inc_AR, inc_PC, inc_DR, inc_AC, inc_TR,
                     seq_counter_RESET, memory_read, memory_write, alu_enable};
      FSel:  return 20'(bus_sel);
      FBus:  return 20'(bus_out);
      FMode: return 20'(alu_mode);
      FRes:  return 20'(alu_result);
      FE:    return 20'(E);
      default: return 'x;
    endcase
  endfunction

  task automatic push(input string tag, input field_e f, input logic [19:0] exp);
    exp_t x;
    x.tag = tag;
    x.f   = f;
    x.exp = exp;
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    logic [19:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs(x.f);
      vectors++;
      assert (o === x.exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", x.tag, o, x.exp);
      end
    end
  endtask

  task automatic comb();
    #1;
    check();
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
    check();
    @(negedge clk);
  endtask

  initial begin
    clr_all = b(SCAR) | b(SCPC) | b(SCDR) | b(SCAC) | b(SCTR);
    reset = 1'b1; T = 8'h04; IR = 8'h50; DR = 8'h00; AC = 8'h00; TR = 8'h00;
    X_DATA = 8'h00; MEM_DATA = 8'h00; AR = 4'h0; PC = 4'h0;
    @(negedge clk);

    push("reset_strobes", FStr, clr_all | b(SSR));
    push("reset_bus_sel", FSel, 20'd0);
    comb();
    push("reset_e", FE, 20'd0);
    clk_edge();

    reset = 1'b0; T = 8'h01; PC = 4'h3; AC = 8'h55;
    push("t0_bus", FBus, 20'h03);
    push("t0_sel", FSel, 20'd2);
    push("t0_strobes", FStr, b(SLAR));
    push("idle_alu_result", FRes, 20'h55);
    comb(); clk_edge();

    T = 8'h02; MEM_DATA = 8'h1A;
    push("t1_strobes", FStr, b(SLIR) | b(SIPC) | b(SMR));
    push("t1_sel", FSel, 20'd7);
    push("t1_bus", FBus, 20'h1A);
    comb(); clk_edge();

    T = 8'h04; IR = 8'h15;
    push("t2_bus", FBus, 20'h15);
    push("t2_strobes", FStr, b(SLAR));
    comb(); clk_edge();

    T = 8'h08;
    push("add_t3_strobes", FStr, b(SMR) | b(SLDR));
    comb(); clk_edge();

    T = 8'h10; AC = 8'hF0; DR = 8'h20;
    push("add_result", FRes, 20'h10);
    push("add_mode", FMode, 20'd1);
    push("add_strobes", FStr, b(SLAC) | b(SSR) | b(SAEN));
    comb();
    push("add_carry_e", FE, 20'd1);
    clk_edge();

    IR = 8'h80; T = 8'h08; AC = 8'h01;
    push("shl_result", FRes, 20'h02);
    comb();
    push("shl_e", FE, 20'd0);
    clk_edge();

    IR = 8'h90; AC = 8'h81;
    push("shr_result", FRes, 20'h40);
    push("shr_strobes", FStr, b(SLAC) | b(SSR) | b(SAEN));
    comb();
    push("shr_e", FE, 20'd1);
    clk_edge();

    IR = 8'h20; T = 8'h10; AC = 8'hF0; DR = 8'h3C;
    push("and_result", FRes, 20'h30);
    push("and_mode", FMode, 20'd2);
    comb();
    push("and_e_hold", FE, 20'd1);
    clk_edge();

    IR = 8'h40; AC = 8'hF0; DR = 8'h3C;
    push("xor_result", FRes, 20'hCC);
    comb(); clk_edge();

    IR = 8'h70; T = 8'h08; AC = 8'h5A;
    push("not_result", FRes, 20'hA5);
    comb(); clk_edge();

    IR = 8'hC7; T = 8'h20; DR = 8'h00;
    push("isz_zero_strobes", FStr, b(SMW) | b(SIPC) | b(SSR));
    push("isz_zero_bus", FBus, 20'h00);
    comb(); clk_edge();

    DR = 8'h05;
    push("isz_nz_strobes", FStr, b(SMW) | b(SSR));
    push("isz_nz_bus", FBus, 20'h05);
    comb(); clk_edge();

    T = 8'h10;
    push("isz_t4_strobes", FStr, b(SIDR));
    comb(); clk_edge();

    IR = 8'h5A; T = 8'h08; AC = 8'h3C;
    push("sta_bus", FBus, 20'h3C);
    push("sta_strobes", FStr, b(SMW) | b(SSR));
    comb(); clk_edge();

    T = 8'h10;
    push("sta_t4_unlisted", FStr, b(SSR));
    comb(); clk_edge();

    IR = 8'h69; T = 8'h08; AR = 4'h9;
    push("jmp_bus", FBus, 20'h09);
    push("jmp_strobes", FStr, b(SLPC) | b(SSR));
    comb(); clk_edge();

    IR = 8'hE0;
    push("nop_strobes", FStr, b(SSR));
    comb(); clk_edge();

    IR = 8'hA0;
    push("cla_strobes", FStr, b(SCAC) | b(SSR));
    comb(); clk_edge();

    IR = 8'hB0;
    push("inc_strobes", FStr, b(SIAC) | b(SSR));
    comb(); clk_edge();

    T = 8'h00;
    push("t_zero_strobes", FStr, b(SSR));
    comb(); clk_edge();

    IR = 8'hE0; T = 8'h0A; MEM_DATA = 8'h6E;
    push("multi_hot_strobes", FStr, b(SLIR) | b(SIPC) | b(SMR));
    push("multi_hot_bus", FBus, 20'h6E);
    comb(); clk_edge();

    IR = 8'hD0; T = 8'h08; X_DATA = 8'h77;
    push("ldx_t3_bus", FBus, 20'h77);
    push("ldx_t3_strobes", FStr, b(SLDR));
    comb(); clk_edge();

    T = 8'h10; DR = 8'h77; AC = 8'h00;
    push("ldx_t4_result", FRes, 20'h77);
    push("ldx_t4_mode", FMode, 20'd0);
    comb();
    push("ldx_e_hold", FE, 20'd1);
    clk_edge();

    reset = 1'b1; IR = 8'h50; T = 8'h08;
    push("reset_sta_strobes", FStr, clr_all | b(SSR));
    push("reset_sta_res", FRes, 20'h00);
    comb();
    push("reset_clears_e", FE, 20'd0);
    clk_edge();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
